inst_cache: RTL and testbench
=============================

# inst_cache

Parametrised, direct-mapped instruction cache that replaces the fixed 64-entry combinational instruction ROM in the Fetch stage. It serves word fetches from an on-chip tag/data array with one-cycle hit latency. On a miss it raises `Imiss`, refills the line from a backing instruction memory over a req/ack handshake, and then delivers the word. It also supports a whole-cache flush.

## Interface
Parameters:
- `ADDR_W`, 32: fetch address width in bits.
- `DATA_W`, 32: instruction word width.
- `LINES`, 64: number of one-word lines. Must be a power of 2, at least 2. `IDX_W = log2(LINES)`.

Ports:
- `Clk` in 1: single clock. Everything is rising-edge.
- `Rst` in 1: reset. Synchronous, active-low.
- `En` in 1: fetch request. Sampled only in READY.
- `Addr` in `ADDR_W`: byte address. Index = `Addr[IDX_W+1:2]`. Tag = `Addr[ADDR_W-1:IDX_W+2]`. `Addr[1:0]` is ignored.
- `Flush` in 1: invalidate all lines.
- `Data` out `DATA_W`: fetched instruction.
- `Valid` out 1: `Data` carries the result of the most recent accepted fetch. One-cycle pulse.
- `Imiss` out 1: a refill is in progress. Fetch must stall.
- `Mem_Req` out 1: refill request to backing memory.
- `Mem_Addr` out `ADDR_W`: word-aligned refill address, with `[1:0]` = 0.
- `Mem_Ack` in 1: backing memory returns `Mem_Data` this cycle.
- `Mem_Data` in `DATA_W`: refill word.

## Operation
- State machine has two states, READY and REFILL. Reset state is READY.
- READY with `En`=1 and `Flush`=0, hit (line valid and tag matches): on the next cycle `Valid`=1, `Data`=array word, stay in READY.
- READY with `En`=1 and `Flush`=0, miss:
  - Latch the address.
  - Next state is REFILL.
  - On the next cycle `Imiss`=1, `Mem_Req`=1, `Mem_Addr`={latched `Addr[ADDR_W-1:2]`, 2'b00}, `Valid`=0.
- REFILL:
  - `Mem_Req`, `Mem_Addr` and `Imiss` are held constant until `Mem_Ack` is sampled 1.
  - On the ack edge: write tag and data, set the line's valid bit, load `Data`=`Mem_Data`.
  - The next cycle shows `Valid`=1, `Imiss`=0, `Mem_Req`=0, and the state is READY.
- `En` is ignored in REFILL. `Mem_Ack` is ignored in READY.
- `En`=0 in READY: `Data` holds its last value, `Valid`=0.
- `Flush` in READY clears every valid bit on that edge. If `En`=1 in the same cycle, the fetch is treated as a miss, so flush wins.
- `Flush` in REFILL: all valid bits are cleared. The refill still completes and delivers `Data`, but the refilled line is left invalid.
- Conflict misses overwrite the indexed line unconditionally. There is no write path from the core.

## Timing
- Reset (`Rst`=0 at an edge) forces:
  - `Data`=0, `Valid`=0, `Imiss`=0, `Mem_Req`=0, `Mem_Addr`=0
  - all valid bits = 0
  - state = READY
- This holds mid-refill too: the request is dropped on the following cycle and a late `Mem_Ack` is ignored.
- Hit latency: `En` at edge N gives `Valid` in cycle N+1.
- Miss latency: `En` at edge N; `Mem_Req` rises in cycle N+1; `Mem_Ack` sampled at edge N+1+k (k ≥ 0); `Valid` in cycle N+2+k.
- `Mem_Ack` may be high in the first `Mem_Req` cycle (k=0), giving a 2-cycle miss.
- Back-to-back hits sustain one fetch per cycle. A new `En` is accepted in the same cycle that `Valid` of the previous fetch is shown.
- The array read is registered. There are no combinational paths from `Addr`/`En` to outputs.

## Structure
- Shared package `inst_cache_pkg` holds:
  - state enum `icache_state_t` {READY, REFILL}
  - default parameter constants
  - an index/tag extraction helper
- Sub-module `icache_array`: valid-bit vector, tag RAM and data RAM.
  - One read port and one write port, synchronous read.
  - Flush clears the valid bits in a single cycle.
- The top level holds the FSM, the latched refill address and the output registers.

## Test plan
- Reset then cold miss: `Addr`=0x0000_0010, `En`=1; `Mem_Ack` after 3 cycles with `Mem_Data`=0xDEAD_BEEF -> `Mem_Addr`=0x10, `Imiss` high for 4 cycles, then `Valid`=1 with `Data`=0xDEAD_BEEF. Refetch 0x10 -> `Valid` next cycle, no `Mem_Req`.
- Back-to-back hits on 0x00, 0x04, 0x08 (all preloaded) -> `Valid`=1 on 3 consecutive cycles with the correct words. `Addr`=0x13 returns the word at 0x10.
- Conflict: with `LINES`=64, fetch 0x0000_0010 then 0x0000_0110 -> the second fetch misses. Refetch 0x10 misses again.
- Zero-wait ack (`Mem_Ack` tied 1) -> miss completes with `Valid` 2 cycles after `En`.
- Flush: preload 0x20, pulse `Flush` together with `En` @0x20 -> miss. Flush during a refill -> data delivered, but an immediate refetch misses.
- `Rst` low during REFILL -> next cycle `Mem_Req`=0, `Imiss`=0, `Data`=0. A late `Mem_Ack` causes no write. A later fetch of the same address misses.

Source files
------------

// File: rtl/inst_cache_pkg.sv
// Shared types, default sizes and address-field helpers for the instruction cache.
package inst_cache_pkg;

  typedef enum logic {
    READY  = 1'b0,
    REFILL = 1'b1
  } icache_state_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LINES  = 64;

  // Helpers work on a zero-extended 64-bit byte address; callers cast to the field width.
  function automatic logic [63:0] line_index(input logic [63:0] byte_addr, input int idx_w);
    return (byte_addr >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] line_tag(input logic [63:0] byte_addr, input int idx_w);
    return byte_addr >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid bits, tag RAM and data RAM for a direct-mapped cache: one synchronous
// read port, one write port, single-cycle flush of all valid bits.
module icache_array #(
  parameter int LINES  = 64,
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 24,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid
);

  logic [LINES-1:0]  valid_bits_reg;
  logic [LINES-1:0]  valid_bits_next;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  // A write during flush carries wr_valid=0, so clearing and writing never disagree.
  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
      assign valid_bits_next[gi] = flush ? 1'b0 :
                                   (wr_en && (wr_idx == IDX_W'(gi))) ? wr_valid :
                                   valid_bits_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_bits_reg <= '0;
      rd_valid       <= 1'b0;
    end else begin
      valid_bits_reg <= valid_bits_next;
      if (rd_en) begin
        rd_valid <= valid_bits_reg[rd_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_tag  <= tag_mem[rd_idx];
      rd_data <= data_mem[rd_idx];
    end
  end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped one-word-line instruction cache with a READY/REFILL controller
// and a req/ack refill port to backing instruction memory.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LINES  = DEF_LINES
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              En,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              Flush,
  output logic [DATA_W-1:0] Data,
  output logic              Valid,
  output logic              Imiss,
  output logic              Mem_Req,
  output logic [ADDR_W-1:0] Mem_Addr,
  input  logic              Mem_Ack,
  input  logic [DATA_W-1:0] Mem_Data
);

  localparam int IDX_W   = $clog2(LINES);
  localparam int TAG_W   = ADDR_W - IDX_W - 2;
  localparam int WADDR_W = ADDR_W - 2;

  icache_state_t      state_reg;
  logic               look_reg;
  logic               force_miss_reg;
  logic               flush_seen_reg;
  logic               fill_valid_reg;
  logic [DATA_W-1:0]  data_reg;
  logic [WADDR_W-1:0] waddr_reg;

  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [DATA_W-1:0]  rd_data;
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   cur_idx;
  logic [TAG_W-1:0]   cur_tag;
  logic               tag_hit;
  logic               hit;
  logic               miss_now;
  logic               in_refill;
  logic               accept;
  logic               fill_done;

  assign rd_idx  = IDX_W'(line_index(64'(Addr), IDX_W));
  assign cur_idx = IDX_W'(line_index(64'({waddr_reg, 2'b00}), IDX_W));
  assign cur_tag = TAG_W'(line_tag(64'({waddr_reg, 2'b00}), IDX_W));

  // The lookup resolves in the cycle after acceptance from the registered array
  // read; a miss found there already behaves as REFILL so Imiss/Mem_Req rise then.
  assign tag_hit   = rd_valid && (rd_tag == cur_tag) && !force_miss_reg;
  assign hit       = look_reg && tag_hit;
  assign miss_now  = look_reg && !tag_hit;
  assign in_refill = (state_reg == REFILL) || miss_now;
  assign accept    = En && (state_reg == READY) && !miss_now;
  assign fill_done = in_refill && Mem_Ack;

  icache_array #(
    .LINES  (LINES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk      (Clk),
    .rst_n    (Rst),
    .flush    (Flush),
    .rd_en    (accept),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill_done),
    .wr_idx   (cur_idx),
    .wr_tag   (cur_tag),
    .wr_data  (Mem_Data),
    .wr_valid (!(flush_seen_reg || Flush))
  );

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_reg      <= READY;
      look_reg       <= 1'b0;
      force_miss_reg <= 1'b0;
      flush_seen_reg <= 1'b0;
      fill_valid_reg <= 1'b0;
      data_reg       <= '0;
      waddr_reg      <= '0;
    end else begin
      look_reg       <= accept;
      fill_valid_reg <= fill_done;
      if (accept) begin
        waddr_reg      <= Addr[ADDR_W-1:2];
        force_miss_reg <= Flush;
      end
      if (hit) begin
        data_reg <= rd_data;
      end
      if (fill_done) begin
        data_reg       <= Mem_Data;
        state_reg      <= READY;
        flush_seen_reg <= 1'b0;
      end else begin
        if (miss_now) begin
          state_reg <= REFILL;
        end
        // A flush seen at any point of the refill keeps the refilled line invalid.
        if (in_refill && Flush) begin
          flush_seen_reg <= 1'b1;
        end
      end
    end
  end

  assign Valid    = hit || fill_valid_reg;
  assign Data     = hit ? rd_data : data_reg;
  assign Imiss    = in_refill;
  assign Mem_Req  = in_refill;
  assign Mem_Addr = {waddr_reg, 2'b00};

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: stimulus pushes expected words, a monitor pops on Valid.
module tb_inst_cache;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        En = 1'b0;
  logic [31:0] Addr = '0;
  logic        Flush = 1'b0;
  logic [31:0] Data;
  logic        Valid;
  logic        Imiss;
  logic        Mem_Req;
  logic [31:0] Mem_Addr;
  logic        Mem_Ack = 1'b0;
  logic [31:0] Mem_Data = '0;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  inst_cache #(
    .ADDR_W (32),
    .DATA_W (32),
    .LINES  (64)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .En       (En),
    .Addr     (Addr),
    .Flush    (Flush),
    .Data     (Data),
    .Valid    (Valid),
    .Imiss    (Imiss),
    .Mem_Req  (Mem_Req),
    .Mem_Addr (Mem_Addr),
    .Mem_Ack  (Mem_Ack),
    .Mem_Data (Mem_Data)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every Valid pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (Valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got data %h, expected no Valid", Data);
      end else begin
        mon_exp = exp_q.pop_front();
        $display("fetch result data=%h expected=%h", Data, mon_exp);
        chk("fetch_data", Data, mon_exp);
      end
    end
  end

  // Issue one fetch; on a miss, ack after k extra Mem_Req cycles with exp_data.
  task automatic fetch(input logic [31:0] a, input bit fl, input bit exp_miss,
                       input int k, input logic [31:0] exp_data);
    int cnt;
    exp_q.push_back(exp_data);
    En = 1'b1; Addr = a; Flush = fl;
    @(negedge Clk);
    En = 1'b0; Flush = 1'b0;
    chk("mem_req", 32'(Mem_Req), 32'(exp_miss));
    if (exp_miss) begin
      chk("mem_addr", Mem_Addr, {a[31:2], 2'b00});
      chk("valid_in_miss", 32'(Valid), 32'd0);
      cnt = 0;
      for (int i = 0; i < k; i++) begin
        if (Imiss) cnt++;
        @(negedge Clk);
        chk("mem_addr_hold", Mem_Addr, {a[31:2], 2'b00});
      end
      if (Imiss) cnt++;
      Mem_Ack = 1'b1; Mem_Data = exp_data;
      @(negedge Clk);
      Mem_Ack = 1'b0;
      chk("imiss_cycles", 32'(cnt), 32'(k + 1));
      chk("imiss_clear", 32'(Imiss), 32'd0);
      chk("req_clear", 32'(Mem_Req), 32'd0);
      chk("valid_after_fill", 32'(Valid), 32'd1);
    end else begin
      chk("valid_hit", 32'(Valid), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_data", Data, 32'd0);
    chk("rst_valid", 32'(Valid), 32'd0);
    chk("rst_imiss", 32'(Imiss), 32'd0);
    chk("rst_mem_req", 32'(Mem_Req), 32'd0);
    chk("rst_mem_addr", Mem_Addr, 32'd0);
    Rst = 1'b1;
    @(negedge Clk);

    // Cold miss with 3-cycle ack wait, then refetch hits.
    fetch(32'h10, 0, 1, 3, 32'hDEAD_BEEF);
    fetch(32'h10, 0, 0, 0, 32'hDEAD_BEEF);

    // Preload 0x00/0x04/0x08 then stream back-to-back hits.
    fetch(32'h00, 0, 1, 1, 32'h1111_0000);
    fetch(32'h04, 0, 1, 0, 32'h2222_0004);
    fetch(32'h08, 0, 1, 2, 32'h3333_0008);
    exp_q.push_back(32'h1111_0000);
    exp_q.push_back(32'h2222_0004);
    exp_q.push_back(32'h3333_0008);
    En = 1'b1; Addr = 32'h00;
    @(negedge Clk);
    chk("b2b_valid0", 32'(Valid), 32'd1);
    chk("b2b_req0", 32'(Mem_Req), 32'd0);
    Addr = 32'h04;
    @(negedge Clk);
    chk("b2b_valid1", 32'(Valid), 32'd1);
    chk("b2b_req1", 32'(Mem_Req), 32'd0);
    Addr = 32'h08;
    @(negedge Clk);
    chk("b2b_valid2", 32'(Valid), 32'd1);
    En = 1'b0;
    @(negedge Clk);
    chk("idle_valid", 32'(Valid), 32'd0);
    chk("idle_data_hold", Data, 32'h3333_0008);

    // Low address bits are ignored.
    fetch(32'h13, 0, 0, 0, 32'hDEAD_BEEF);
    @(negedge Clk);
    chk("idle_data_hold2", Data, 32'hDEAD_BEEF);

    // Conflict on index 4.
    fetch(32'h110, 0, 1, 1, 32'hAAAA_0110);
    fetch(32'h10, 0, 1, 0, 32'hBBBB_0010);
    fetch(32'h10, 0, 0, 0, 32'hBBBB_0010);

    // Mem_Ack tied high: 2-cycle miss, and ack ignored in READY.
    Mem_Ack = 1'b1; Mem_Data = 32'hCCCC_0040;
    exp_q.push_back(32'hCCCC_0040);
    En = 1'b1; Addr = 32'h40;
    @(negedge Clk);
    En = 1'b0;
    chk("zw_req", 32'(Mem_Req), 32'd1);
    chk("zw_valid_early", 32'(Valid), 32'd0);
    @(negedge Clk);
    chk("zw_valid", 32'(Valid), 32'd1);
    chk("zw_imiss", 32'(Imiss), 32'd0);
    @(negedge Clk);
    chk("zw_ack_ignored_valid", 32'(Valid), 32'd0);
    chk("zw_ack_ignored_req", 32'(Mem_Req), 32'd0);
    Mem_Ack = 1'b0;

    // Flush together with En forces a miss; flush clears other lines too.
    fetch(32'h20, 0, 1, 0, 32'h5555_0020);
    fetch(32'h20, 0, 0, 0, 32'h5555_0020);
    fetch(32'h20, 1, 1, 1, 32'h6666_0020);
    fetch(32'h20, 0, 0, 0, 32'h6666_0020);
    fetch(32'h00, 0, 1, 0, 32'h7777_0000);

    // Flush during refill: data delivered, line left invalid.
    exp_q.push_back(32'h8888_0030);
    En = 1'b1; Addr = 32'h30;
    @(negedge Clk);
    En = 1'b0;
    chk("fr_req", 32'(Mem_Req), 32'd1);
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    chk("fr_req_hold", 32'(Mem_Req), 32'd1);
    Mem_Ack = 1'b1; Mem_Data = 32'h8888_0030;
    @(negedge Clk);
    Mem_Ack = 1'b0;
    chk("fr_valid", 32'(Valid), 32'd1);
    fetch(32'h30, 0, 1, 0, 32'h9999_0030);

    // Reset during refill drops the request; a late ack writes nothing.
    En = 1'b1; Addr = 32'h50;
    @(negedge Clk);
    En = 1'b0;
    chk("rr_req", 32'(Mem_Req), 32'd1);
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    chk("rr_mem_req", 32'(Mem_Req), 32'd0);
    chk("rr_imiss", 32'(Imiss), 32'd0);
    chk("rr_data", Data, 32'd0);
    chk("rr_valid", 32'(Valid), 32'd0);
    Mem_Ack = 1'b1; Mem_Data = 32'hEEEE_0050;
    @(negedge Clk);
    Mem_Ack = 1'b0;
    chk("rr_late_ack_valid", 32'(Valid), 32'd0);
    fetch(32'h50, 0, 1, 1, 32'h1234_0050);
    fetch(32'h30, 0, 1, 0, 32'h1357_0030);

    repeat (3) @(negedge Clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
